// File: rtl/gadget_drop_ctrl.sv
// Falling gadget capsule controller: holds capsules, advances them once per frame and detects platform catches.
// Optional macro GADGET_MISS_CNT_EN adds o_miss_cnt, a saturating count of capsules lost at the bottom.

`ifndef PIXELX_BIT_CNT
`define PIXELX_BIT_CNT 10
`endif
`ifndef PIXELY_BIT_CNT
`define PIXELY_BIT_CNT 10
`endif
`ifndef GADGET_BIT_CNT
`define GADGET_BIT_CNT 3
`endif
`ifndef PLAT_HF_WIDTH_BIT_CNT
`define PLAT_HF_WIDTH_BIT_CNT 8
`endif

module gadget_drop_ctrl #(
   parameter int unsigned SLOT_NUM      = 4,
   parameter int unsigned FALL_STEP     = 2,
   parameter int unsigned CAP_HALF_W    = 8,
   parameter int unsigned CAP_HALF_H    = 4,
   parameter int unsigned SCREEN_BOTTOM = 480
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic                                     i_game_start,
   input  logic                                     i_cal_frame,
   input  logic                                     i_spawn_valid,
   input  logic [`PIXELX_BIT_CNT-1:0]               i_spawn_x,
   input  logic [`PIXELY_BIT_CNT-1:0]               i_spawn_y,
   input  logic [`GADGET_BIT_CNT-1:0]               i_spawn_effect,
   output logic                                     o_spawn_ready,
   input  logic [`PIXELX_BIT_CNT-1:0]               i_platX,
   input  logic [`PIXELY_BIT_CNT-1:0]               i_platY,
   input  logic [`PLAT_HF_WIDTH_BIT_CNT-1:0]        i_plat_size,
   output logic                                     o_plat_receive_gadget,
   output logic [`GADGET_BIT_CNT-1:0]               o_plat_gadget_effect,
   output logic [SLOT_NUM-1:0]                      o_slot_valid,
   output logic [SLOT_NUM*`PIXELX_BIT_CNT-1:0]      o_slot_x,
   output logic [SLOT_NUM*`PIXELY_BIT_CNT-1:0]      o_slot_y,
   output logic [SLOT_NUM*`GADGET_BIT_CNT-1:0]      o_slot_effect,
   output logic                                     o_busy
`ifdef GADGET_MISS_CNT_EN
   ,
   output logic [7:0]                               o_miss_cnt
`endif
);

   localparam int unsigned XW   = `PIXELX_BIT_CNT;
   localparam int unsigned YW   = `PIXELY_BIT_CNT;
   localparam int unsigned GW   = `GADGET_BIT_CNT;
   localparam int unsigned PW   = `PLAT_HF_WIDTH_BIT_CNT;
   localparam int unsigned IW   = (SLOT_NUM > 1) ? $clog2(SLOT_NUM) : 1;
   localparam int unsigned DW   = ((XW > PW) ? XW : PW) + 2;
   localparam int unsigned YN_W = YW + 2;

   typedef enum logic {S_IDLE, S_SCAN} state_t;

   state_t              state;
   logic [IW-1:0]       idx;
   logic [SLOT_NUM-1:0] slot_valid;
   logic [XW-1:0]       slot_x   [SLOT_NUM];
   logic [YW-1:0]       slot_y   [SLOT_NUM];
   logic [GW-1:0]       slot_eff [SLOT_NUM];

   logic                any_free;
   logic [IW-1:0]       free_idx;
   logic [YN_W-1:0]     cur_yn;
   logic [DW-1:0]       dx;
   logic [DW-1:0]       x_lim;
   logic                hit_y;
   logic                catch_c;
   logic                miss_c;

   // lowest-index free slot
   always_comb begin
      any_free = 1'b0;
      free_idx = '0;
      for (int i = SLOT_NUM - 1; i >= 0; i--) begin
         if (!slot_valid[i]) begin
            any_free = 1'b1;
            free_idx = IW'(i);
         end
      end
   end

   assign o_spawn_ready = (state == S_IDLE) && any_free && !i_game_start;

   // catch / miss evaluation of the slot under scan; lower Y bound rearranged to avoid underflow
   always_comb begin
      cur_yn  = YN_W'(slot_y[idx]) + YN_W'(FALL_STEP);
      dx      = (slot_x[idx] >= i_platX) ? (DW'(slot_x[idx]) - DW'(i_platX))
                                         : (DW'(i_platX) - DW'(slot_x[idx]));
      x_lim   = DW'(i_plat_size) + DW'(CAP_HALF_W);
      hit_y   = ((cur_yn + YN_W'(CAP_HALF_H)) >= YN_W'(i_platY)) &&
                (cur_yn <= (YN_W'(i_platY) + YN_W'(CAP_HALF_H)));
      catch_c = slot_valid[idx] && hit_y && (dx <= x_lim);
      miss_c  = slot_valid[idx] && !catch_c &&
                (cur_yn >= YN_W'(SCREEN_BOTTOM + CAP_HALF_H));
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state                 <= S_IDLE;
         idx                   <= '0;
         slot_valid            <= '0;
         o_busy                <= 1'b0;
         o_plat_receive_gadget <= 1'b0;
         o_plat_gadget_effect  <= '0;
         for (int i = 0; i < SLOT_NUM; i++) begin
            slot_x[i]   <= '0;
            slot_y[i]   <= '0;
            slot_eff[i] <= '0;
         end
      end else if (i_game_start) begin
         state                 <= S_IDLE;
         idx                   <= '0;
         slot_valid            <= '0;
         o_busy                <= 1'b0;
         o_plat_receive_gadget <= 1'b0;
         for (int i = 0; i < SLOT_NUM; i++) begin
            slot_x[i]   <= '0;
            slot_y[i]   <= '0;
            slot_eff[i] <= '0;
         end
      end else begin
         o_plat_receive_gadget <= 1'b0;
         if (state == S_IDLE) begin
            if (i_spawn_valid && o_spawn_ready) begin
               slot_valid[free_idx] <= 1'b1;
               slot_x[free_idx]     <= i_spawn_x;
               slot_y[free_idx]     <= i_spawn_y;
               slot_eff[free_idx]   <= i_spawn_effect;
            end
            if (i_cal_frame) begin
               state  <= S_SCAN;
               idx    <= '0;
               o_busy <= 1'b1;
            end
         end else begin
            if (catch_c) begin
               slot_valid[idx]       <= 1'b0;
               o_plat_receive_gadget <= 1'b1;
               o_plat_gadget_effect  <= slot_eff[idx];
            end else if (miss_c) begin
               slot_valid[idx] <= 1'b0;
            end else if (slot_valid[idx]) begin
               slot_y[idx] <= YW'(cur_yn);
            end
            if (idx == IW'(SLOT_NUM - 1)) begin
               state  <= S_IDLE;
               idx    <= '0;
               o_busy <= 1'b0;
            end else begin
               idx <= idx + IW'(1);
            end
         end
      end
   end

`ifdef GADGET_MISS_CNT_EN
   // saturating count of capsules lost at the screen bottom
   always_ff @(posedge clk) begin
      if (rst || i_game_start) begin
         o_miss_cnt <= '0;
      end else if ((state == S_SCAN) && miss_c && (o_miss_cnt != 8'hFF)) begin
         o_miss_cnt <= o_miss_cnt + 8'd1;
      end
   end
`endif

   // renderer view, slot 0 in the LSBs
   always_comb begin
      o_slot_valid = slot_valid;
      for (int i = 0; i < SLOT_NUM; i++) begin
         o_slot_x[i*XW +: XW]      = slot_x[i];
         o_slot_y[i*YW +: YW]      = slot_y[i];
         o_slot_effect[i*GW +: GW] = slot_eff[i];
      end
   end

endmodule
